// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared FSM encoding, segment tile patterns and tile codes for the scan driver.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_BLANK
    } state_e;

    // Active-low {dp,g,f,e,d,c,b,a} patterns recognised as game tiles
    localparam logic [7:0] PAT_BLANK      = 8'hFF;
    localparam logic [7:0] PAT_GROUND     = 8'h77;
    localparam logic [7:0] PAT_BARRIER    = 8'h73;
    localparam logic [7:0] PAT_BIRD       = 8'h75;
    localparam logic [7:0] PAT_DOWN_ROLE  = 8'h23;
    localparam logic [7:0] PAT_UP_ROLE    = 8'h14;
    localparam logic [7:0] PAT_UNDER_BIRD = 8'h21;
    localparam logic [7:0] PAT_JUMP_OVER  = 8'h10;

    localparam logic [3:0] TILE_BLANK      = 4'd0;
    localparam logic [3:0] TILE_GROUND     = 4'd1;
    localparam logic [3:0] TILE_BARRIER    = 4'd2;
    localparam logic [3:0] TILE_BIRD       = 4'd3;
    localparam logic [3:0] TILE_DOWN_ROLE  = 4'd4;
    localparam logic [3:0] TILE_UP_ROLE    = 4'd5;
    localparam logic [3:0] TILE_UNDER_BIRD = 4'd6;
    localparam logic [3:0] TILE_JUMP_OVER  = 4'd7;
    localparam logic [3:0] TILE_OTHER      = 4'd8;

endpackage

// File: rtl/tile_classify.sv
// tile_classify: combinational map from one segment pattern to its tile code.
module tile_classify
    import seg_scan_pkg::*;
(
    input  logic [7:0] pattern_i,
    output logic [3:0] code_o
);

    always_comb
        code_o = pattern_i == PAT_BLANK      ? TILE_BLANK      :
                 pattern_i == PAT_GROUND     ? TILE_GROUND     :
                 pattern_i == PAT_BARRIER    ? TILE_BARRIER    :
                 pattern_i == PAT_BIRD       ? TILE_BIRD       :
                 pattern_i == PAT_DOWN_ROLE  ? TILE_DOWN_ROLE  :
                 pattern_i == PAT_UP_ROLE    ? TILE_UP_ROLE    :
                 pattern_i == PAT_UNDER_BIRD ? TILE_UNDER_BIRD :
                 pattern_i == PAT_JUMP_OVER  ? TILE_JUMP_OVER  : TILE_OTHER;

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit multiplexed 7-segment scanner with anti-ghost blanking,
// PWM brightness and tear-free double-buffered patterns swapped at frame boundaries.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int SCAN_DIV     = 12500,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [7:0]  Map1,
    input  logic [7:0]  Map2,
    input  logic [7:0]  Map3,
    input  logic [7:0]  Map4,
    input  logic        load,
    input  logic [2:0]  brightness,
    output logic [7:0]  seg_out,
    output logic [3:0]  dig_en,
    output logic [15:0] tile_code,
    output logic        frame_done
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] DRV_LAST  = CW'(SCAN_DIV - BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        dig_q, dig_d;
    logic [2:0]        pwm_q, pwm_d, bri_q, bri_d;
    logic [3:0][7:0]   pend_q, pend_d, act_q, act_d, map;
    logic              pv_q, pv_d;
    logic [7:0]        seg_d;
    logic [3:0]        en_d;

    assign map = {Map4, Map3, Map2, Map1};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dig_d      = dig_q;
        pwm_d      = pwm_q;
        bri_d      = bri_q;
        pend_d     = pend_q;
        act_d      = act_q;
        pv_d       = pv_q;
        frame_done = state_q == ST_BLANK && cnt_q == SLOT_LAST && dig_q == 2'd3;
        if (load) begin
            pend_d = map;
            pv_d   = 1'b1;
        end
        case (state_q)
            ST_IDLE: if (load) begin
                state_d = ST_DRIVE;
                act_d   = map;
                pv_d    = 1'b0;
                cnt_d   = '0;
                dig_d   = '0;
                pwm_d   = '0;
            end
            ST_DRIVE: begin
                cnt_d = cnt_q + 1'b1;
                pwm_d = pwm_q + 1'b1;
                if (cnt_q == DRV_LAST) state_d = ST_BLANK;
            end
            default: if (cnt_q == SLOT_LAST) begin
                state_d = ST_DRIVE;
                cnt_d   = '0;
                pwm_d   = '0;
                dig_d   = dig_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        endcase
        // A load landing on the boundary bypasses pending and goes live directly
        if (frame_done) begin
            bri_d = brightness;
            pv_d  = 1'b0;
            act_d = load ? map : pv_q ? pend_q : act_q;
        end
        seg_d = state_q == ST_DRIVE && pwm_q <= bri_q ? act_q[dig_q] : 8'hFF;
        en_d  = state_q == ST_DRIVE ? ~(4'b0001 << dig_q) : 4'hF;
    end

    always_ff @(posedge clk or negedge Reset)
        if (!Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dig_q   <= '0;
            pwm_q   <= '0;
            bri_q   <= 3'd7;
            pend_q  <= '1;
            act_q   <= '1;
            pv_q    <= 1'b0;
            seg_out <= 8'hFF;
            dig_en  <= 4'hF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            pwm_q   <= pwm_d;
            bri_q   <= bri_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            pv_q    <= pv_d;
            seg_out <= seg_d;
            dig_en  <= en_d;
        end

    for (genvar i = 0; i < 4; i++) begin : g_tile
        tile_classify u_tile (
            .pattern_i (act_q[i]),
            .code_o    (tile_code[4*i +: 4])
        );
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed + randomized checks of seg_scan_driver against a
// cycle-count model of the scan schedule, frame buffering and PWM.
module tb_seg_scan_driver;

    localparam int SD = 16;
    localparam int BC = 4;
    localparam int FR = 4 * SD;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  Map1 = 8'h00, Map2 = 8'h00, Map3 = 8'h00, Map4 = 8'h00;
    logic [2:0]  brightness = 3'd7;
    logic [7:0]  seg_out;
    logic [3:0]  dig_en;
    logic [15:0] tile_code;
    logic        frame_done;

    int nvec = 0;
    int nerr = 0;

    seg_scan_driver #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .Map1       (Map1),
        .Map2       (Map2),
        .Map3       (Map3),
        .Map4       (Map4),
        .load       (load),
        .brightness (brightness),
        .seg_out    (seg_out),
        .dig_en     (dig_en),
        .tile_code  (tile_code),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Model: k counts clocks since the load that left idle; slot, digit and
    // PWM phase all follow from k by division.
    bit         run;
    int         k;
    int         bri;
    bit         pv;
    logic [7:0] act[4];
    logic [7:0] pend[4];

    function automatic logic [3:0] tile(input logic [7:0] p);
        case (p)
            8'hFF: return 4'd0;
            8'h77: return 4'd1;
            8'h73: return 4'd2;
            8'h75: return 4'd3;
            8'h23: return 4'd4;
            8'h14: return 4'd5;
            8'h21: return 4'd6;
            8'h10: return 4'd7;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [7:0] rp();
        logic [7:0] tbl[8];
        tbl = '{8'hFF, 8'h77, 8'h73, 8'h75, 8'h23, 8'h14, 8'h21, 8'h10};
        return $urandom_range(0, 8) == 8 ? 8'($urandom) : tbl[$urandom_range(0, 7)];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        run = 0;
        k   = 0;
        pv  = 0;
        bri = 7;
        for (int i = 0; i < 4; i++) begin
            act[i]  = 8'hFF;
            pend[i] = 8'hFF;
        end
    endtask

    task automatic check_all(input logic [7:0] es, input logic [3:0] ee);
        chk("seg_out", 32'(seg_out), 32'(es));
        chk("dig_en", 32'(dig_en), 32'(ee));
        chk("frame_done", 32'(frame_done), 32'(run && k % FR == FR - 1));
        chk("tile_code", 32'(tile_code),
            32'({tile(act[3]), tile(act[2]), tile(act[1]), tile(act[0])}));
    endtask

    task automatic tick(input bit ld, input logic [7:0] m0, input logic [7:0] m1,
                        input logic [7:0] m2, input logic [7:0] m3, input logic [2:0] b);
        logic [7:0] es;
        logic [3:0] ee;
        logic [7:0] m[4];
        bit         bnd;
        int         d;
        m  = '{m0, m1, m2, m3};
        es = 8'hFF;
        ee = 4'hF;
        load = ld;
        Map1 = m0;
        Map2 = m1;
        Map3 = m2;
        Map4 = m3;
        brightness = b;
        // pins after this edge reflect the model state before it
        if (run && k % SD < SD - BC) begin
            d  = (k / SD) % 4;
            ee = ~(4'b0001 << d);
            es = ((k % SD) % 8 <= bri) ? act[d] : 8'hFF;
        end
        if (Reset) begin
            if (!run) begin
                if (ld) begin
                    run  = 1;
                    k    = 0;
                    act  = m;
                    pend = m;
                    pv   = 0;
                end
            end else begin
                bnd = (k % FR == FR - 1);
                if (bnd) begin
                    bri = b;
                    if (ld) act = m;
                    else if (pv) act = pend;
                    pv = 0;
                end
                if (ld) begin
                    pend = m;
                    pv   = !bnd;
                end
                k++;
            end
        end
        @(posedge clk);
        #1;
        load = 1'b0;
        check_all(es, ee);
    endtask

    initial begin
        model_reset();
        repeat (3) tick(1'b1, rp(), rp(), rp(), rp(), 3'd7);
        Reset = 1'b1;
        repeat (200) tick(1'b0, rp(), rp(), rp(), rp(), 3'($urandom));
        tick(1'b1, 8'h77, 8'h73, 8'h75, 8'h23, 3'd7);
        repeat (2 * FR) tick(1'b0, rp(), rp(), rp(), rp(), 3'd7);
        repeat (20) tick(1'b0, rp(), rp(), rp(), rp(), 3'd7);
        tick(1'b1, 8'h14, 8'h14, 8'h14, 8'h14, 3'd7);
        repeat (2 * FR + 2) tick(1'b0, rp(), rp(), rp(), rp(), 3'd7);
        chk("tile_up_role", 32'(tile_code), 32'h5555);
        while (k % FR != FR - 1) tick(1'b0, rp(), rp(), rp(), rp(), 3'd7);
        tick(1'b1, rp(), rp(), rp(), rp(), 3'd7);
        repeat (FR + 6) tick(1'b0, rp(), rp(), rp(), rp(), 3'd7);
        repeat (2 * FR + 12) tick(1'b0, rp(), rp(), rp(), rp(), 3'd1);
        repeat (400) tick($urandom_range(0, 19) == 0, rp(), rp(), rp(), rp(), 3'($urandom));
        while (k % FR != 30) tick(1'b0, rp(), rp(), rp(), rp(), 3'd3);
        #2 Reset = 1'b0;
        #1;
        model_reset();
        check_all(8'hFF, 4'hF);
        repeat (5) tick(1'b1, rp(), rp(), rp(), rp(), 3'd2);
        Reset = 1'b1;
        repeat (20) tick(1'b0, rp(), rp(), rp(), rp(), 3'd7);
        tick(1'b1, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 3'd7);
        chk("tile_other", 32'(tile_code), 32'h8888);
        repeat (FR + 8) tick(1'b0, rp(), rp(), rp(), rp(), 3'd7);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
